seq_alu: RTL and testbench

Parametrised multi-cycle ALU for the tiny16 datapath, the successor to the single-cycle ALU. Logic, add/sub and shift/rotate ops complete in one cycle; multiply (shift-add) and divide (restoring) are iterative over WIDTH cycles. The block uses valid/ready handshakes on both sides so the control unit can stall on long operations. It returns a full-width secondary result (high product or remainder) plus O C N Z flags.

---
 rtl/seq_alu.sv | 226 ++++++++++++++++++++++
 tb/tb_seq_alu.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Multi-cycle ALU for the tiny16 datapath: single-cycle logic/add/shift ops, iterative
// shift-add multiply and restoring divide, with valid/ready handshakes on both sides.
module seq_alu #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic             ar_flag,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rem,
  output logic [3:0]       flags
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] CntLast = SHW'(WIDTH - 1);

  localparam logic [3:0] OpAdd = 4'b0011;
  localparam logic [3:0] OpSub = 4'b0100;
  localparam logic [3:0] OpMul = 4'b0101;
  localparam logic [3:0] OpDiv = 4'b0110;
  localparam logic [3:0] OpAnd = 4'b0111;
  localparam logic [3:0] OpOr  = 4'b1000;
  localparam logic [3:0] OpXor = 4'b1001;
  localparam logic [3:0] OpShl = 4'b1010;
  localparam logic [3:0] OpShr = 4'b1011;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e           state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] opa_q, opa_d;   // multiplicand or divisor
  logic [WIDTH-1:0] hi_q, hi_d;     // partial high product or partial remainder
  logic [WIDTH-1:0] lo_q, lo_d;     // multiplier/low product or dividend/quotient
  logic             divz_q, divz_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [3:0]       flags_q, flags_d;

  logic accept;

  assign in_ready  = !rst && ((state_q == StIdle) || ((state_q == StDone) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == StDone);
  assign out       = out_q;
  assign rem       = rem_q;
  assign flags     = flags_q;

  // Single-cycle datapath, evaluated on the live operands at the accept edge.
  logic [SHW-1:0]     amt;
  logic [SHW:0]       rol_back;
  logic [WIDTH:0]     add_wide;
  logic [WIDTH:0]     shl_wide;
  logic [WIDTH:0]     shr_wide;
  logic signed [WIDTH:0] sar_wide;
  logic [WIDTH-1:0]   rol_res;

  assign amt      = src2[SHW-1:0];
  assign rol_back = (SHW+1)'(WIDTH) - {1'b0, amt};
  assign add_wide = {1'b0, src1} + {1'b0, src2};
  assign shl_wide = {1'b0, src1} << amt;
  assign shr_wide = {src1, 1'b0} >> amt;
  assign sar_wide = $signed({src1, 1'b0}) >>> amt;
  assign rol_res  = (src1 << amt) | (src1 >> rol_back);

  logic [WIDTH-1:0] sc_out;
  logic             sc_c;
  logic             sc_o;
  logic [3:0]       sc_flags;

  always_comb begin
    sc_out = '0;
    sc_c   = 1'b0;
    sc_o   = 1'b0;
    case (opcode)
      OpAdd: begin
        {sc_c, sc_out} = add_wide;
        sc_o = (src1[WIDTH-1] == src2[WIDTH-1]) && (add_wide[WIDTH-1] != src1[WIDTH-1]);
      end
      OpSub: begin
        sc_out = src1 - src2;
        sc_c   = (src1 < src2);
        sc_o   = (src1[WIDTH-1] != src2[WIDTH-1]) && (sc_out[WIDTH-1] != src1[WIDTH-1]);
      end
      OpAnd: sc_out = src1 & src2;
      OpOr:  sc_out = src1 | src2;
      OpXor: sc_out = src1 ^ src2;
      OpShl: begin
        if (ar_flag) begin
          sc_out = rol_res;
          sc_c   = (amt != '0) && rol_res[0];
        end else begin
          {sc_c, sc_out} = shl_wide;
        end
      end
      OpShr: begin
        if (ar_flag) begin
          {sc_out, sc_c} = sar_wide;
        end else begin
          {sc_out, sc_c} = shr_wide;
        end
      end
      default: begin
        sc_out = '0;
        sc_c   = 1'b0;
        sc_o   = 1'b0;
      end
    endcase
  end

  assign sc_flags = {sc_o, sc_c, sc_out[WIDTH-1], (sc_out == '0)};

  // One shift-add multiply step: add, then shift {carry, hi, lo} right by one.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_nxt;
  logic [WIDTH-1:0] mul_lo_nxt;

  assign mul_sum    = {1'b0, hi_q} + ({1'b0, opa_q} & {(WIDTH+1){lo_q[0]}});
  assign mul_hi_nxt = mul_sum[WIDTH:1];
  assign mul_lo_nxt = {mul_sum[0], lo_q[WIDTH-1:1]};

  // One restoring divide step. A zero divisor always succeeds, which yields an all-ones
  // quotient and shifts the whole dividend into the remainder.
  logic [WIDTH:0]   div_trial;
  logic             div_ge;
  logic [WIDTH-1:0] div_hi_nxt;
  logic [WIDTH-1:0] div_lo_nxt;

  assign div_trial  = {hi_q, lo_q[WIDTH-1]} - {1'b0, opa_q};
  assign div_ge     = !div_trial[WIDTH];
  assign div_hi_nxt = div_ge ? div_trial[WIDTH-1:0] : {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
  assign div_lo_nxt = {lo_q[WIDTH-2:0], div_ge};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    divz_d  = divz_q;
    out_d   = out_q;
    rem_d   = rem_q;
    flags_d = flags_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          cnt_d = '0;
          hi_d  = '0;
          if (opcode == OpMul) begin
            state_d = StMul;
            opa_d   = src1;
            lo_d    = src2;
          end else if (opcode == OpDiv) begin
            state_d = StDiv;
            opa_d   = src2;
            lo_d    = src1;
            divz_d  = (src2 == '0);
          end else begin
            state_d = StDone;
            out_d   = sc_out;
            rem_d   = '0;
            flags_d = sc_flags;
          end
        end else if ((state_q == StDone) && out_ready) begin
          state_d = StIdle;
        end
      end
      StMul: begin
        hi_d  = mul_hi_nxt;
        lo_d  = mul_lo_nxt;
        cnt_d = cnt_q + SHW'(1);
        if (cnt_q == CntLast) begin
          state_d = StDone;
          out_d   = mul_lo_nxt;
          rem_d   = mul_hi_nxt;
          flags_d = {(mul_hi_nxt != '0), (mul_hi_nxt != '0), mul_lo_nxt[WIDTH-1],
                     (mul_lo_nxt == '0)};
        end
      end
      StDiv: begin
        hi_d  = div_hi_nxt;
        lo_d  = div_lo_nxt;
        cnt_d = cnt_q + SHW'(1);
        if (cnt_q == CntLast) begin
          state_d = StDone;
          out_d   = div_lo_nxt;
          rem_d   = div_hi_nxt;
          flags_d = {divz_q, 1'b0, div_lo_nxt[WIDTH-1], (div_lo_nxt == '0)};
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      opa_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      divz_q  <= 1'b0;
      out_q   <= '0;
      rem_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      divz_q  <= divz_d;
      out_q   <= out_d;
      rem_q   <= rem_d;
      flags_q <= flags_d;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu: inputs change and outputs are sampled on the
// falling clock edge, away from the active rising edge.
module tb_seq_alu;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   opcode = 4'h0;
  logic         ar_flag = 1'b0;
  logic [W-1:0] src1 = '0;
  logic [W-1:0] src2 = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out;
  logic [W-1:0] rem;
  logic [3:0]   flags;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .opcode   (opcode),
    .ar_flag  (ar_flag),
    .src1     (src1),
    .src2     (src2),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (out),
    .rem      (rem),
    .flags    (flags)
  );

  // Misc single-cycle op table: opcode, ar_flag, src1, src2, expected out, expected flags.
  logic [3:0]   t_op  [9] = '{4'h9, 4'h7, 4'h8, 4'hA, 4'hA, 4'hB, 4'h0, 4'h3, 4'h4};
  logic         t_ar  [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [W-1:0] t_a   [9] = '{16'hF0F0, 16'h00FF, 16'h8000, 16'h8001, 16'h1234, 16'h8003,
                              16'h1234, 16'hFFFF, 16'h8000};
  logic [W-1:0] t_b   [9] = '{16'hFFFF, 16'hFF00, 16'h0001, 16'h0001, 16'h0010, 16'h0001,
                              16'h5678, 16'h0001, 16'h0001};
  logic [W-1:0] t_out [9] = '{16'h0F0F, 16'h0000, 16'h8001, 16'h0002, 16'h1234, 16'h4001,
                              16'h0000, 16'h0000, 16'h7FFF};
  logic [3:0]   t_flg [9] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0000, 4'b0100,
                              4'b0001, 4'b0101, 4'b1000};

  task automatic issue(input logic [3:0] op, input logic ar, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    in_valid = 1'b1;
    opcode   = op;
    ar_flag  = ar;
    src1     = a;
    src2     = b;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({out_valid, in_ready} !== 2'b00)
      $display("FAIL reset_hs: got valid/ready %b want 00", {out_valid, in_ready});
    else n_pass++;
    n_checks++;
    if ({out, rem, flags} !== 36'h0)
      $display("FAIL reset_regs: got out=%h rem=%h flags=%b want 0", out, rem, flags);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", in_ready);
    else n_pass++;
  endtask

  task automatic test_add();
    out_ready = 1'b1;
    issue(4'b0011, 1'b0, 16'h7FFF, 16'h0001);
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if ({out_valid, out, rem, flags} !== {1'b1, 16'h8000, 16'h0000, 4'b1010})
      $display("FAIL add_ovf: got v=%b out=%h rem=%h flags=%b want v=1 out=8000 rem=0000 flags=1010",
               out_valid, out, rem, flags);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({out_valid, flags} !== {1'b0, 4'b1010})
      $display("FAIL add_one_cycle: got v=%b flags=%b want v=0 flags=1010", out_valid, flags);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    issue(4'b0100, 1'b0, 16'h0000, 16'h0001);
    @(negedge clk);
    n_checks++;
    if ({out_valid, in_ready, out, flags} !== {1'b1, 1'b1, 16'hFFFF, 4'b0110})
      $display("FAIL sub_borrow: got v=%b rdy=%b out=%h flags=%b want v=1 rdy=1 out=ffff flags=0110",
               out_valid, in_ready, out, flags);
    else n_pass++;
    issue(4'b1011, 1'b1, 16'h8000, 16'h000F);
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if ({out_valid, out, flags} !== {1'b1, 16'hFFFF, 4'b0010})
      $display("FAIL sar15: got v=%b out=%h flags=%b want v=1 out=ffff flags=0010",
               out_valid, out, flags);
    else n_pass++;
    @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      issue(t_op[i], t_ar[i], t_a[i], t_b[i]);
      @(negedge clk);
      n_checks++;
      if ({out_valid, out, rem, flags} !== {1'b1, t_out[i], 16'h0000, t_flg[i]})
        $display("FAIL op_table[%0d]: got v=%b out=%h rem=%h flags=%b want v=1 out=%h rem=0000 flags=%b",
                 i, out_valid, out, rem, flags, t_out[i], t_flg[i]);
      else n_pass++;
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL table_drain: got v=%b want 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_mul();
    int bad = 0;
    out_ready = 1'b1;
    issue(4'b0101, 1'b0, 16'h1234, 16'h0100);
    @(negedge clk);
    // Keep requesting junk during the iteration; none of it may be accepted.
    for (int i = 0; i < 16; i++) begin
      if (out_valid !== 1'b0 || in_ready !== 1'b0) bad++;
      in_valid = (i < 15);
      opcode   = 4'b0011;
      src1     = W'($urandom);
      src2     = W'($urandom);
      @(negedge clk);
    end
    n_checks++;
    if (bad != 0) $display("FAIL mul_stall: got %0d bad cycles want 0", bad);
    else n_pass++;
    n_checks++;
    if ({out_valid, out, rem, flags} !== {1'b1, 16'h3400, 16'h0012, 4'b1100})
      $display("FAIL mul_result: got v=%b out=%h rem=%h flags=%b want v=1 out=3400 rem=0012 flags=1100",
               out_valid, out, rem, flags);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_div();
    int cyc;
    out_ready = 1'b1;
    issue(4'b0110, 1'b0, 16'd1000, 16'd7);
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (cyc != 16) $display("FAIL div_latency: got %0d want 16", cyc);
    else n_pass++;
    n_checks++;
    if ({out, rem, flags} !== {16'h008E, 16'h0006, 4'b0000})
      $display("FAIL div_result: got out=%h rem=%h flags=%b want out=008e rem=0006 flags=0000",
               out, rem, flags);
    else n_pass++;
    @(negedge clk);
    issue(4'b0110, 1'b0, 16'h1234, 16'h0000);
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if ({cyc == 16, out, rem, flags} !== {1'b1, 16'hFFFF, 16'h1234, 4'b1010})
      $display("FAIL div_zero: got cyc=%0d out=%h rem=%h flags=%b want cyc=16 out=ffff rem=1234 flags=1010",
               cyc, out, rem, flags);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int bad = 0;
    out_ready = 1'b0;
    issue(4'b1010, 1'b1, 16'h8001, 16'h0001);
    @(negedge clk);
    n_checks++;
    if ({out_valid, out, rem, flags} !== {1'b1, 16'h0003, 16'h0000, 4'b0100})
      $display("FAIL rol_result: got v=%b out=%h rem=%h flags=%b want v=1 out=0003 rem=0000 flags=0100",
               out_valid, out, rem, flags);
    else n_pass++;
    issue(4'b0011, 1'b0, 16'h7FFF, 16'h0001);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if ({out_valid, in_ready, out, rem, flags} !== {2'b10, 16'h0003, 16'h0000, 4'b0100})
        bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL bp_hold: got %0d unstable cycles want 0", bad);
    else n_pass++;
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", in_ready);
    else n_pass++;
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if ({out_valid, out, flags} !== {1'b1, 16'h8000, 4'b1010})
      $display("FAIL bp_new_op: got v=%b out=%h flags=%b want v=1 out=8000 flags=1010",
               out_valid, out, flags);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_div();
    out_ready = 1'b1;
    issue(4'b0110, 1'b0, 16'hFFFF, 16'h0003);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({out_valid, in_ready, out, rem, flags} !== {2'b00, 16'h0000, 16'h0000, 4'b0000})
      $display("FAIL rst_abort: got v=%b rdy=%b out=%h rem=%h flags=%b want all 0",
               out_valid, in_ready, out, rem, flags);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01)
      $display("FAIL rst_recover: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
    else n_pass++;
    issue(4'b0011, 1'b0, 16'd2, 16'd3);
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if ({out_valid, out, rem, flags} !== {1'b1, 16'h0005, 16'h0000, 4'b0000})
      $display("FAIL rst_then_add: got v=%b out=%h rem=%h flags=%b want v=1 out=0005 rem=0000 flags=0000",
               out_valid, out, rem, flags);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL rst_then_add_drain: got v=%b want 0", out_valid);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_mul();
    test_div();
    test_backpressure();
    test_reset_mid_div();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
